shaper_scaled: RTL and testbench
================================

Name: shaper_scaled

Overview:
- Next-generation pixel shaper between the display timing generator and the framebuffer read port.
- Maps screen coordinates to framebuffer coordinates using a run-time integer downscale of 1x, 2x or 4x, latched once per frame.
- Looks up the returned pixel index in a writable, registered colour palette.
- Outputs pipelined RGB with a valid strobe, and substitutes a border colour for screen pixels that fall outside the source image.

Parameters:
- WIDTH, 640, screen width in pixels
- HEIGHT, 480, screen height in lines
- SRC_WIDTH, 320, framebuffer width in pixels
- SRC_HEIGHT, 240, framebuffer height in lines
- COORD_BITS, 10, width of all coordinate ports
- BPP, 3, palette index width (1..4)

Ports:
- aClock  in  1  pixel clock
- aReset  in  1  asynchronous, active-high reset
- aX  in  COORD_BITS  screen column
- aY  in  COORD_BITS  screen row
- aValid  in  1  aX/aY is an active pixel this cycle
- aScaleMode  in  2  0=1x, 1=2x, 2=4x, 3=reserved (treated as 1x)
- anOutMemX  out  COORD_BITS  framebuffer column
- anOutMemY  out  COORD_BITS  framebuffer row
- anOutMemRead  out  1  read strobe to framebuffer
- aPixelData  in  BPP  framebuffer data, valid one cycle after anOutMemRead
- aPalWrite  in  1  palette write enable
- aPalIndex  in  BPP  palette entry to write
- aPalColour  in  24  {R,G,B} to write
- aBorderColour  in  24  {R,G,B} for out-of-image pixels
- anOutRed  out  8  red
- anOutGreen  out  8  green
- anOutBlue  out  8  blue
- anOutValid  out  1  RGB outputs are valid

Behaviour:
- Single clock domain. Reset is asynchronous and active-high on aReset.
- Reset values:
  - all outputs 0
  - active shift = 0 (1x)
  - pipeline valid and border flags cleared
  - palette entry i = grey: R=G=B={i, zero-fill} left-aligned to 8 bits (e.g. BPP=3, i=7 -> 8'hE0)
- Scale latch:
  - The active shift (0, 1 or 2) is updated from aScaleMode only on a cycle where aValid=1 and aX=0 and aY=0 (frame start).
  - That same pixel already uses the new shift.
  - aScaleMode changes at any other time have no effect until the next frame start.
- Stage 1 (cycle N+1 for input at N):
  - anOutMemX = aX >> shift; anOutMemY = aY >> shift (logical shift, zero-extended, no rounding).
  - border = (aX >> shift) >= SRC_WIDTH or (aY >> shift) >= SRC_HEIGHT.
  - anOutMemRead = aValid and not border. When that is 0, anOutMemX/anOutMemY hold their previous values.
  - Any aValid=1 input with aX >= WIDTH or aY >= HEIGHT is treated as border.
- Stage 2 (N+2): aPixelData is sampled. Valid and border flags are delayed alongside it.
- Stage 3 (N+3):
  - RGB = aBorderColour if border, else palette[aPixelData]; anOutValid = delayed aValid.
  - When the delayed valid is 0, RGB is driven to 0.
- Total latency from aX/aY to RGB is 3 cycles. There are no bubbles; the pipeline accepts one pixel per cycle and has no backpressure.
- Palette:
  - 2^BPP x 24 flops; a write takes effect at the clock edge.
  - A stage-2 read of an entry written in the same cycle returns the old value (read-before-write). The new value is seen from the next cycle.
  - Writes are allowed at any time, including during active video.
- Reset asserted mid-line: all pipeline valids clear immediately and anOutValid=0 asynchronously. The palette returns to the grey default and the shift returns to 1x.
- Reserved mode 3 latches as shift 0.

Decomposition:
- Package shaper_pkg:
  - typedef rgb_t (packed 8/8/8)
  - enum scale_mode_e (SCALE_1X, SCALE_2X, SCALE_4X)
  - function mode_to_shift
  - function grey_default(index)
- Sub-module palette_ram: parametrised by BPP; one write port, one registered-address combinational read; owns the reset defaults.
- shaper_scaled contains the scale latch, the address stage and the flag delay line.

Test Plan:
- Reset -> all outputs 0, anOutValid=0. With mode 1x, drive aValid=1, aX=0, aY=0, aPixelData=5 at N+2 -> at N+3 RGB = 8'hA0/8'hA0/8'hA0, anOutValid=1.
- Frame start with aScaleMode=1, then aX=5, aY=9 -> anOutMemX=2, anOutMemY=4 one cycle later. With aScaleMode=2, aX=639, aY=479 -> memX=159, memY=119.
- Mode 2x latched, then aScaleMode set to 2 mid-frame -> aX=8 still gives memX=4. After the next frame start, aX=8 gives memX=2.
- 1x mode, aX=400, aY=10, aBorderColour=24'h123456 -> anOutMemRead=0 and at N+3 RGB = 12/34/56. Then aX=319 -> anOutMemRead=1 with the palette colour.
- Write entry 2 = 24'hFF8000 in the same cycle stage 2 reads index 2 -> that output is the grey default 8'h40. The next index-2 pixel gives FF/80/00.
- Assert aReset while 3 valid pixels are in flight -> anOutValid=0 immediately, no valid output after release until new input plus 3 cycles, and palette entry 2 is back to the grey default.

Source files
------------

// File: rtl/shaper_pkg.sv
// Shared types and helpers for the scaled pixel shaper: RGB layout, scale
// encodings and the grey palette defaults.
package shaper_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Value doubles as the right-shift applied to screen coordinates.
    typedef enum logic [1:0] {
        SCALE_1X = 2'd0,
        SCALE_2X = 2'd1,
        SCALE_4X = 2'd2
    } scale_mode_e;

    function automatic scale_mode_e mode_to_shift(input logic [1:0] mode);
        case (mode)
            2'd1:    return SCALE_2X;
            2'd2:    return SCALE_4X;
            default: return SCALE_1X;
        endcase
    endfunction

    function automatic rgb_t grey_default(input int unsigned index, input int unsigned bpp);
        logic [7:0] w_level;
        w_level = 8'(index << (8 - bpp));
        return '{r: w_level, g: w_level, b: w_level};
    endfunction

endpackage

// File: rtl/palette_ram.sv
// Colour palette: 2^BPP flop entries, one write port, combinational read.
// Reset restores the grey ramp.
module palette_ram
    import shaper_pkg::*;
#(
    parameter int unsigned BPP = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_wr_en,
    input  logic [BPP-1:0] i_wr_index,
    input  rgb_t           i_wr_colour,
    input  logic [BPP-1:0] i_rd_index,
    output rgb_t           o_rd_colour
);

    localparam int unsigned DEPTH = 1 << BPP;

    rgb_t r_entries [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entries[i] <= grey_default(i, BPP);
            end
        end else if (i_wr_en) begin
            r_entries[i_wr_index] <= i_wr_colour;
        end
    end

    assign o_rd_colour = r_entries[i_rd_index];

endmodule

// File: rtl/shaper_scaled.sv
// Pixel shaper: per-frame integer downscale of screen coordinates, framebuffer
// address generation, border substitution and palette lookup, 3-cycle latency.
module shaper_scaled
    import shaper_pkg::*;
#(
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned SRC_WIDTH  = 320,
    parameter int unsigned SRC_HEIGHT = 240,
    parameter int unsigned COORD_BITS = 10,
    parameter int unsigned BPP        = 3
) (
    input  logic                  aClock,
    input  logic                  aReset,
    input  logic [COORD_BITS-1:0] aX,
    input  logic [COORD_BITS-1:0] aY,
    input  logic                  aValid,
    input  logic [1:0]            aScaleMode,
    output logic [COORD_BITS-1:0] anOutMemX,
    output logic [COORD_BITS-1:0] anOutMemY,
    output logic                  anOutMemRead,
    input  logic [BPP-1:0]        aPixelData,
    input  logic                  aPalWrite,
    input  logic [BPP-1:0]        aPalIndex,
    input  logic [23:0]           aPalColour,
    input  logic [23:0]           aBorderColour,
    output logic [7:0]            anOutRed,
    output logic [7:0]            anOutGreen,
    output logic [7:0]            anOutBlue,
    output logic                  anOutValid
);

    scale_mode_e           r_shift;
    logic [COORD_BITS-1:0] r_mem_x;
    logic [COORD_BITS-1:0] r_mem_y;
    logic                  r_mem_read;
    logic                  r_valid1;
    logic                  r_border1;
    logic                  r_valid2;
    logic                  r_border2;
    logic                  r_out_valid;
    rgb_t                  r_out_rgb;

    logic                  w_frame_start;
    scale_mode_e           w_shift;
    logic [COORD_BITS-1:0] w_src_x;
    logic [COORD_BITS-1:0] w_src_y;
    logic                  w_border;
    logic                  w_read;
    rgb_t                  w_pal_colour;

    // The frame-start pixel itself already uses the newly latched shift.
    always_comb begin
        w_frame_start = aValid && (aX == '0) && (aY == '0);
        w_shift       = w_frame_start ? mode_to_shift(aScaleMode) : r_shift;
        w_src_x       = aX >> w_shift;
        w_src_y       = aY >> w_shift;
        w_border      = (32'(aX) >= WIDTH) || (32'(aY) >= HEIGHT) ||
                        (32'(w_src_x) >= SRC_WIDTH) || (32'(w_src_y) >= SRC_HEIGHT);
        w_read        = aValid && !w_border;
    end

    palette_ram #(
        .BPP (BPP)
    ) u_palette (
        .i_clk       (aClock),
        .i_rst       (aReset),
        .i_wr_en     (aPalWrite),
        .i_wr_index  (aPalIndex),
        .i_wr_colour (rgb_t'(aPalColour)),
        .i_rd_index  (aPixelData),
        .o_rd_colour (w_pal_colour)
    );

    // Pixel sampling and palette lookup share the output register: the lookup
    // sees pre-write palette contents, giving read-before-write behaviour.
    always_ff @(posedge aClock or posedge aReset) begin
        if (aReset) begin
            r_shift     <= SCALE_1X;
            r_mem_x     <= '0;
            r_mem_y     <= '0;
            r_mem_read  <= 1'b0;
            r_valid1    <= 1'b0;
            r_border1   <= 1'b0;
            r_valid2    <= 1'b0;
            r_border2   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_rgb   <= '0;
        end else begin
            r_shift    <= w_shift;
            r_mem_read <= w_read;
            if (w_read) begin
                r_mem_x <= w_src_x;
                r_mem_y <= w_src_y;
            end
            r_valid1    <= aValid;
            r_border1   <= aValid && w_border;
            r_valid2    <= r_valid1;
            r_border2   <= r_border1;
            r_out_valid <= r_valid2;
            if (!r_valid2) begin
                r_out_rgb <= '0;
            end else if (r_border2) begin
                r_out_rgb <= rgb_t'(aBorderColour);
            end else begin
                r_out_rgb <= w_pal_colour;
            end
        end
    end

    assign anOutMemX    = r_mem_x;
    assign anOutMemY    = r_mem_y;
    assign anOutMemRead = r_mem_read;
    assign anOutRed     = r_out_rgb.r;
    assign anOutGreen   = r_out_rgb.g;
    assign anOutBlue    = r_out_rgb.b;
    assign anOutValid   = r_out_valid;

endmodule

// File: tb/tb_shaper_scaled.sv
// Bench for shaper_scaled: directed scenarios plus random traffic, all checked
// against a cycle-indexed reference model of the shaper's rules.
module tb_shaper_scaled;

    localparam int unsigned CB   = 10;
    localparam int unsigned BPP  = 3;
    localparam int unsigned NCYC = 4096;

    logic           aClock = 1'b0;
    logic           aReset = 1'b1;
    logic [CB-1:0]  aX = '0, aY = '0;
    logic           aValid = 1'b0;
    logic [1:0]     aScaleMode = '0;
    logic [CB-1:0]  anOutMemX, anOutMemY;
    logic           anOutMemRead;
    logic [BPP-1:0] aPixelData = '0;
    logic           aPalWrite = 1'b0;
    logic [BPP-1:0] aPalIndex = '0;
    logic [23:0]    aPalColour = '0, aBorderColour = '0;
    logic [7:0]     anOutRed, anOutGreen, anOutBlue;
    logic           anOutValid;

    shaper_scaled #(
        .WIDTH(640), .HEIGHT(480), .SRC_WIDTH(320), .SRC_HEIGHT(240),
        .COORD_BITS(CB), .BPP(BPP)
    ) dut (
        .aClock(aClock), .aReset(aReset), .aX(aX), .aY(aY), .aValid(aValid),
        .aScaleMode(aScaleMode), .anOutMemX(anOutMemX), .anOutMemY(anOutMemY),
        .anOutMemRead(anOutMemRead), .aPixelData(aPixelData), .aPalWrite(aPalWrite),
        .aPalIndex(aPalIndex), .aPalColour(aPalColour), .aBorderColour(aBorderColour),
        .anOutRed(anOutRed), .anOutGreen(anOutGreen), .anOutBlue(anOutBlue),
        .anOutValid(anOutValid)
    );

    always #5 aClock = ~aClock;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model, indexed by cycle number.
    int unsigned cur = 0;
    int unsigned m_shift = 0;
    bit [23:0]   m_pal [1 << BPP];
    bit          x_mrd [NCYC];
    bit [CB-1:0] x_mx  [NCYC];
    bit [CB-1:0] x_my  [NCYC];
    bit          x_ov  [NCYC];
    bit [23:0]   x_rgb [NCYC];
    bit          p_val [NCYC];
    bit          p_bor [NCYC];

    // Stimulus for the next cycle.
    logic           d_valid = 1'b0;
    logic [CB-1:0]  d_x = '0, d_y = '0;
    logic [1:0]     d_mode = '0;
    logic [BPP-1:0] d_pix = '0;
    logic           d_pwr = 1'b0;
    logic [BPP-1:0] d_pidx = '0;
    logic [23:0]    d_pcol = '0, d_bcol = '0;

    function automatic bit [23:0] grey(input int unsigned i);
        bit [7:0] lvl;
        lvl = 8'(i * (256 >> BPP));
        return {lvl, lvl, lvl};
    endfunction

    task automatic model_reset();
        m_shift = 0;
        for (int unsigned i = 0; i < (1 << BPP); i++) m_pal[i] = grey(i);
    endtask

    task automatic step();
        int unsigned sx, sy;
        bit          bor;
        @(posedge aClock);
        #1;
        cur++;
        check("memRead",  32'(anOutMemRead), 32'(x_mrd[cur]));
        check("memX",     32'(anOutMemX),    32'(x_mx[cur]));
        check("memY",     32'(anOutMemY),    32'(x_my[cur]));
        check("outValid", 32'(anOutValid),   32'(x_ov[cur]));
        check("rgb", 32'({anOutRed, anOutGreen, anOutBlue}), 32'(x_rgb[cur]));

        aValid = d_valid; aX = d_x; aY = d_y; aScaleMode = d_mode;
        aPixelData = d_pix; aPalWrite = d_pwr; aPalIndex = d_pidx;
        aPalColour = d_pcol; aBorderColour = d_bcol;

        if (d_valid && d_x == 0 && d_y == 0) m_shift = (d_mode == 2'd3) ? 0 : int'(d_mode);
        sx  = int'(d_x) / (1 << m_shift);
        sy  = int'(d_y) / (1 << m_shift);
        bor = (d_x >= 640) || (d_y >= 480) || (sx >= 320) || (sy >= 240);
        p_val[cur] = d_valid;
        p_bor[cur] = bor;
        x_mrd[cur+1] = d_valid && !bor;
        x_mx[cur+1]  = x_mrd[cur+1] ? CB'(sx) : x_mx[cur];
        x_my[cur+1]  = x_mrd[cur+1] ? CB'(sy) : x_my[cur];
        if (cur >= 2 && p_val[cur-2]) begin
            x_ov[cur+1]  = 1'b1;
            x_rgb[cur+1] = p_bor[cur-2] ? d_bcol : m_pal[d_pix];
        end else begin
            x_ov[cur+1]  = 1'b0;
            x_rgb[cur+1] = '0;
        end
        if (d_pwr) m_pal[d_pidx] = d_pcol;
    endtask

    task automatic px(input int unsigned x, input int unsigned y, input int unsigned mode);
        d_valid = 1'b1; d_x = CB'(x); d_y = CB'(y); d_mode = 2'(mode);
    endtask

    task automatic idle();
        d_valid = 1'b0; d_pwr = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle, held over two edges.
    task automatic do_reset();
        #2;
        aReset = 1'b1; aValid = 1'b0; aPalWrite = 1'b0;
        #1;
        check("rst_outValid", 32'(anOutValid), 32'd0);
        check("rst_rgb",  32'({anOutRed, anOutGreen, anOutBlue}), 32'd0);
        check("rst_memRead", 32'(anOutMemRead), 32'd0);
        repeat (2) begin
            @(posedge aClock);
            cur++;
        end
        #3;
        aReset = 1'b0;
        model_reset();
        p_val[cur] = 1'b0; p_val[cur-1] = 1'b0;
        x_mrd[cur+1] = 1'b0; x_mx[cur+1] = '0; x_my[cur+1] = '0;
        x_ov[cur+1] = 1'b0; x_rgb[cur+1] = '0;
    endtask

    initial begin
        model_reset();
        #12;
        check("init_outValid", 32'(anOutValid), 32'd0);
        check("init_rgb", 32'({anOutRed, anOutGreen, anOutBlue}), 32'd0);
        check("init_memRead", 32'(anOutMemRead), 32'd0);
        check("init_memX", 32'(anOutMemX), 32'd0);
        check("init_memY", 32'(anOutMemY), 32'd0);
        #1 aReset = 1'b0;

        // First pixel, grey palette entry 5.
        px(0, 0, 0); step();
        idle(); step();
        d_pix = 3'd5; step();
        step();
        check("first_red", 32'(anOutRed), 32'hA0);
        check("first_valid", 32'(anOutValid), 32'd1);

        // Scale latch at frame start.
        px(0, 0, 1); step();
        px(5, 9, 1); step();
        idle(); step();
        check("x2_memX", 32'(anOutMemX), 32'd2);
        check("x2_memY", 32'(anOutMemY), 32'd4);
        px(0, 0, 2); step();
        px(639, 479, 2); step();
        idle(); step();
        check("x4_memX", 32'(anOutMemX), 32'd159);
        check("x4_memY", 32'(anOutMemY), 32'd119);

        // Mid-frame mode change is ignored until the next frame start.
        px(0, 0, 1); step();
        px(8, 0, 2); step();
        idle(); step();
        check("midframe_memX", 32'(anOutMemX), 32'd4);
        px(0, 0, 2); step();
        px(8, 0, 2); step();
        idle(); step();
        check("newframe_memX", 32'(anOutMemX), 32'd2);

        // Border substitution and the last in-image column.
        d_bcol = 24'h123456;
        px(0, 0, 0); step();
        px(400, 10, 0); step();
        idle(); step();
        check("border_memRead", 32'(anOutMemRead), 32'd0);
        step(); step();
        check("border_rgb", 32'({anOutRed, anOutGreen, anOutBlue}), 32'h123456);
        px(319, 10, 0); step();
        idle(); step();
        check("edge_memRead", 32'(anOutMemRead), 32'd1);
        check("edge_memX", 32'(anOutMemX), 32'd319);

        // Palette read-before-write.
        px(1, 1, 0); step();
        idle(); step();
        d_pix = 3'd2; d_pwr = 1'b1; d_pidx = 3'd2; d_pcol = 24'hFF8000; step();
        d_pwr = 1'b0; step();
        check("rbw_old", 32'({anOutRed, anOutGreen, anOutBlue}), 32'h404040);
        px(1, 1, 0); step();
        idle(); step();
        d_pix = 3'd2; step();
        step();
        check("rbw_new", 32'({anOutRed, anOutGreen, anOutBlue}), 32'hFF8000);

        // Reset with pixels in flight, after a scale change.
        px(0, 0, 2); step();
        for (int unsigned i = 1; i <= 3; i++) begin
            px(i, 1, 2); step();
        end
        do_reset();
        idle(); step(); step();
        px(8, 1, 0); step();
        idle(); step();
        check("post_rst_memX", 32'(anOutMemX), 32'd8);
        d_pix = 3'd2; step();
        step();
        check("post_rst_pal", 32'({anOutRed, anOutGreen, anOutBlue}), 32'h404040);

        // Random traffic.
        for (int unsigned n = 0; n < 700; n++) begin
            d_valid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) begin
                d_x = '0; d_y = '0;
            end else if ($urandom_range(0, 3) == 0) begin
                d_x = CB'($urandom_range(0, 1023)); d_y = CB'($urandom_range(0, 1023));
            end else begin
                d_x = CB'($urandom_range(0, 639)); d_y = CB'($urandom_range(0, 479));
            end
            d_mode = 2'($urandom_range(0, 3));
            d_pix  = BPP'($urandom_range(0, (1 << BPP) - 1));
            d_pwr  = ($urandom_range(0, 3) == 0);
            d_pidx = BPP'($urandom_range(0, (1 << BPP) - 1));
            d_pcol = 24'($urandom);
            if ($urandom_range(0, 31) == 0) d_bcol = 24'($urandom);
            step();
            if (n == 350) do_reset();
        end
        idle();
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
